// File: rtl/asic_ifetch_if.sv
// Fetch-unit bus bundle: ROM read port plus the instruction valid/ready port
// toward the decoder. The master modport is the fetch sequencer side.
interface asic_ifetch_if #(
    parameter int D_WIDTH    = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  rom_ena;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [D_WIDTH-1:0]    rom_data;
    logic [D_WIDTH-1:0]    instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;

    modport master (
        output rom_ena, rom_addr, instr, instr_pc, instr_valid,
        input  rom_data, instr_ready
    );

    modport slave (
        input  rom_ena, rom_addr, instr, instr_pc, instr_valid,
        output rom_data, instr_ready
    );
endinterface

// File: rtl/asic_ifetch.sv
// Instruction fetch sequencer. Issues ROM reads from the PC, absorbs the
// ROM's one-cycle read latency and hands words to the decoder through a
// 2-entry skid FIFO. Stops on the halt opcode; supports redirect with flush.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | issuing reads and capturing returned words
// DRAIN | halt word captured, no more reads, waiting for FIFO to empty
// HALT  | halt word delivered, waiting for start
module asic_ifetch #(
    parameter int                    D_WIDTH    = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [3:0]            HALT_OP    = 4'hF,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                  clka_i,
    input  logic                  rsta_i,
    input  logic                  start_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  busy_o,
    output logic                  halted_o,
    asic_ifetch_if.master         bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic [D_WIDTH-1:0]    mem_data_q [2];
    logic [D_WIDTH-1:0]    mem_data_d [2];
    logic [ADDR_WIDTH-1:0] mem_pc_q [2];
    logic [ADDR_WIDTH-1:0] mem_pc_d [2];
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  halt_seen;
    logic                  redirect_ok;
    logic [2:0]            credit;

    // Next-state and datapath: issue, capture, pop, then start/redirect overrides
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        ipc_d      = ipc_q;
        mem_data_d = mem_data_q;
        mem_pc_d   = mem_pc_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;

        pop         = (cnt_q != 2'd0) && bus.instr_ready;
        credit      = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
        issue       = (state_q == RUN) && (credit < 3'd2);
        // A word returning after the halt word (state already DRAIN) is dropped.
        push        = inflight_q && (state_q == RUN);
        halt_seen   = push && (bus.rom_data[D_WIDTH-1 -: 4] == HALT_OP);
        redirect_ok = redirect_i && ((state_q == RUN) || (state_q == DRAIN));

        inflight_d = issue;
        if (issue) begin
            ipc_d = pc_q;
            pc_d  = pc_q + 1'b1;
        end
        if (push) begin
            mem_data_d[wr_q] = bus.rom_data;
            mem_pc_d[wr_q]   = ipc_q;
            wr_d             = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + 2'(push) - 2'(pop);

        case (state_q)
            RUN: begin
                if (halt_seen) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && (cnt_q == 2'd1)) state_d = HALT;
            end
            IDLE, HALT: begin
                if (start_i) begin
                    state_d    = RUN;
                    pc_d       = START_ADDR;
                    inflight_d = 1'b0;
                    cnt_d      = 2'd0;
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect beats everything while busy; the same-cycle pop has already been counted.
        if (redirect_ok) begin
            state_d    = RUN;
            pc_d       = redirect_addr_i;
            inflight_d = 1'b0;
            cnt_d      = 2'd0;
            rd_d       = 1'b0;
            wr_d       = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clka_i or posedge rsta_i) begin
        if (rsta_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // PC, in-flight tracking and FIFO storage
    always_ff @(posedge clka_i or posedge rsta_i) begin
        if (rsta_i) begin
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            ipc_q         <= '0;
            mem_data_q[0] <= '0;
            mem_data_q[1] <= '0;
            mem_pc_q[0]   <= '0;
            mem_pc_q[1]   <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            cnt_q         <= 2'd0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            ipc_q      <= ipc_d;
            mem_data_q <= mem_data_d;
            mem_pc_q   <= mem_pc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.rom_ena     = issue;
    assign bus.rom_addr    = pc_q;
    assign bus.instr       = mem_data_q[rd_q];
    assign bus.instr_pc    = mem_pc_q[rd_q];
    assign bus.instr_valid = (cnt_q != 2'd0);
    assign busy_o          = (state_q == RUN) || (state_q == DRAIN);
    assign halted_o        = (state_q == HALT);

endmodule

// File: tb/tb_asic_ifetch.sv
// Directed bench for asic_ifetch: stream to halt, restart, backpressure,
// redirect, PC wrap and asynchronous reset mid-stream.
module tb_asic_ifetch;

    logic       clk;
    logic       rst;
    logic       start;
    logic       redirect;
    logic [7:0] redirect_addr;
    logic       busy;
    logic       halted;
    int         n_checks;
    int         n_errors;
    int         max_addr;

    logic [15:0] rom [256];
    logic [15:0] prog [16];

    asic_ifetch_if #(.D_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    asic_ifetch #(
        .D_WIDTH(16), .ADDR_WIDTH(8), .HALT_OP(4'hF), .START_ADDR(8'd0)
    ) dut (
        .clka_i          (clk),
        .rsta_i          (rst),
        .start_i         (start),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .busy_o          (busy),
        .halted_o        (halted),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered-read ROM model
    always @(posedge clk) begin
        if (bus.rom_ena) bus.rom_data <= rom[bus.rom_addr];
    end

    // highest address ever issued
    always @(posedge clk) begin
        if (!rst && bus.rom_ena && (int'(bus.rom_addr) > max_addr)) max_addr = int'(bus.rom_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] w, input logic [7:0] pc);
        chk({tag, "_instr"}, 32'(bus.instr), 32'(w));
        chk({tag, "_pc"},    32'(bus.instr_pc), 32'(pc));
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_instr"},   32'(bus.instr), 32'd0);
        chk({tag, "_pc"},      32'(bus.instr_pc), 32'd0);
        chk({tag, "_valid"},   32'(bus.instr_valid), 32'd0);
        chk({tag, "_rom_ena"}, 32'(bus.rom_ena), 32'd0);
        chk({tag, "_addr"},    32'(bus.rom_addr), 32'd0);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_halted"},  32'(halted), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        max_addr = 0;
        prog = '{16'h5000, 16'h310F, 16'h321A, 16'h5100, 16'h3126, 16'h4200, 16'h1234, 16'h2345,
                 16'h7001, 16'h3103, 16'h8002, 16'h9003, 16'hA004, 16'hB005, 16'h6200, 16'hF000};
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 16; i++) rom[i] = prog[i];

        rst = 1'b1; start = 1'b0; redirect = 1'b0; redirect_addr = 8'd0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // stream to halt
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("first_ena",  32'(bus.rom_ena), 32'd1);
        chk("first_addr", 32'(bus.rom_addr), 32'd0);
        chk("first_busy", 32'(busy), 32'd1);
        chk("first_nval", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        chk("lat_nval", 32'(bus.instr_valid), 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk_word("stream", prog[k], 8'(k));
        end
        chk("drain_no_ena", 32'(bus.rom_ena), 32'd0);
        chk("drain_busy",   32'(busy), 32'd1);
        chk("drain_nhalt",  32'(halted), 32'd0);
        @(negedge clk);
        chk("halted",      32'(halted), 32'd1);
        chk("halt_nbusy",  32'(busy), 32'd0);
        chk("halt_nval",   32'(bus.instr_valid), 32'd0);
        chk("max_addr",    32'(max_addr), 32'd16);

        // restart after halt, with a start pulse mid-run that must be ignored
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("restart_ena",  32'(bus.rom_ena), 32'd1);
        chk("restart_addr", 32'(bus.rom_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk_word("restart0", 16'h5000, 8'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk_word("restart1", 16'h310F, 8'd1);

        // backpressure
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_word("stall", 16'h310F, 8'd1);
            chk("stall_no_ena", 32'(bus.rom_ena), 32'd0);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk_word("release1", 16'h321A, 8'd2);
        @(negedge clk);
        chk_word("release2", 16'h5100, 8'd3);

        // redirect to 9 while 5100 is at head (popped this cycle)
        redirect = 1'b1; redirect_addr = 8'd9;
        @(negedge clk); redirect = 1'b0;
        chk("redir_nval", 32'(bus.instr_valid), 32'd0);
        chk("redir_ena",  32'(bus.rom_ena), 32'd1);
        chk("redir_addr", 32'(bus.rom_addr), 32'd9);
        @(negedge clk);
        chk("redir_nval2", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        chk_word("redir0", 16'h3103, 8'd9);
        @(negedge clk);
        chk_word("redir1", 16'h8002, 8'd10);

        // wrap through 255
        redirect = 1'b1; redirect_addr = 8'd255;
        @(negedge clk); redirect = 1'b0;
        chk("wrap_ena",  32'(bus.rom_ena), 32'd1);
        chk("wrap_addr", 32'(bus.rom_addr), 32'd255);
        @(negedge clk);
        chk("wrap_nval", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        chk_word("wrap255", 16'h0000, 8'd255);
        @(negedge clk);
        chk_word("wrap0", 16'h5000, 8'd0);
        @(negedge clk);
        chk_word("wrap1", 16'h310F, 8'd1);
        chk("wrap_busy",   32'(busy), 32'd1);
        chk("wrap_nhalt",  32'(halted), 32'd0);
        @(negedge clk);
        chk_word("wrap2", 16'h321A, 8'd2);
        @(negedge clk);
        chk_word("wrap3", 16'h5100, 8'd3);
        @(negedge clk);
        chk_word("pre_reset", 16'h3126, 8'd4);

        // asynchronous reset mid-stream
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_ena", 32'(bus.rom_ena), 32'd0);
        chk("post_rst_nval",   32'(bus.instr_valid), 32'd0);
        chk("post_rst_nbusy",  32'(busy), 32'd0);
        @(negedge clk);
        chk("post_rst_no_ena2", 32'(bus.rom_ena), 32'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("post_rst_ena",  32'(bus.rom_ena), 32'd1);
        chk("post_rst_addr", 32'(bus.rom_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk_word("post_rst0", 16'h5000, 8'd0);
        @(negedge clk);
        chk_word("post_rst1", 16'h310F, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
